branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Consumes the 3-bit status flags produced by the 16-bit ALU: {V overflow, N negative, Z zero}.
- Holds those flags in a status register and evaluates branch conditions against them.
- Returns the resolved next PC to the fetch stage through a valid/ready handshake with a single-entry output register.
- Also keeps a sticky overflow flag readable by control logic.

Parameters:
- W, 16, datapath/PC width (matches ALU width)
- PC_INC, 1, fall-through PC increment added when a branch is not taken

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flags_we  input  1  load flags_in into the status register this cycle
- flags_in  input  3  ALU flags: [2]=V, [1]=N, [0]=Z
- req_valid  input  1  branch request present
- req_ready  output  1  unit can accept a request this cycle
- req_cond  input  3  condition code
- req_pc  input  W  PC of the branch instruction
- req_target  input  W  branch target address
- resp_valid  output  1  resolved result held in the output register
- resp_ready  input  1  consumer accepts the result
- resp_taken  output  1  condition evaluated true
- resp_next_pc  output  W  next PC
- flags_q  output  3  current status register
- sticky_v  output  1  sticky overflow flag
- sticky_clr  input  1  clear sticky_v

Behaviour:
- Clock and reset:
  - clk is the single clock; rst_n is asynchronous and active-low.
  - While rst_n=0: flags_q=3'b000, sticky_v=0, resp_valid=0, resp_taken=0, resp_next_pc=0, state=IDLE.
  - Reset mid-transaction discards any held response with no further output.
- Status register:
  - flags_q <= flags_in on any rising edge with flags_we=1; otherwise it holds.
- Sticky overflow:
  - sticky_v <= 1 when flags_we=1 and flags_in[2]=1.
  - Else sticky_v <= 0 when sticky_clr=1.
  - Set has priority over clear in the same cycle.
- Evaluation flags (eff):
  - eff = flags_in when flags_we=1 in the acceptance cycle (same-cycle bypass); otherwise eff = flags_q.
- Condition codes, with V=eff[2], N=eff[1], Z=eff[0], signed compare:
  - 000 ALWAYS: 1
  - 001 EQ: Z
  - 010 NE: !Z
  - 011 LT: N^V
  - 100 LE: (N^V)|Z
  - 101 GE: !(N^V)
  - 110 GT: !(N^V)&!Z
  - 111 VS: V
- Next PC:
  - resp_next_pc = taken ? req_target : req_pc+PC_INC, truncated to W bits (wraps modulo 2^W).
- FSM:
  - IDLE: req_ready=1. On req_valid, the request is accepted: the output register is loaded and the state goes to FULL. With no req_valid, the state stays IDLE.
  - FULL: resp_valid=1; outputs are stable until the handshake.
    - resp_ready=1 with req_valid=1: the new request is accepted in the same cycle, the output register is reloaded, and the state stays FULL (back-to-back, one result per cycle).
    - resp_ready=1 with req_valid=0: the state goes to IDLE.
    - resp_ready=0: hold.
  - req_ready = (state==IDLE) | resp_ready. This is combinational from resp_ready only; there is no path from req_valid.
- Latency: a request accepted at edge k has resp_valid=1 after edge k.
- Request inputs are sampled only at acceptance; they are don't-care at other times.
- Flag updates while in FULL do not alter the held response.

Test Plan:
- Reset and flag load:
  - Assert rst_n=0 mid-FULL -> resp_valid, flags_q and sticky_v drop to 0 immediately, without waiting for a clock edge.
  - Then flags_we=1, flags_in=3'b010 -> flags_q=3'b010.
- Condition sweep:
  - flags_q=3'b010 (N=1, V=0); for each cond 000..111 issue req_pc=16'h0010, req_target=16'h0100.
  - Expected taken: ALWAYS 1, EQ 0, NE 1, LT 1, LE 1, GE 0, GT 0, VS 0.
  - next_pc is 16'h0100 when taken and 16'h0011 otherwise.
- Bypass:
  - flags_q=3'b000; in the same cycle drive flags_we=1, flags_in=3'b001 and req EQ -> resp_taken=1, resp_next_pc=target.
- Wrap-around:
  - req_pc=16'hFFFF, cond NE with Z=1 -> taken=0, resp_next_pc=16'h0000.
- Backpressure and streaming:
  - Hold resp_ready=0 for 3 cycles -> response stable and req_ready=0.
  - Then resp_ready=1 with continuous req_valid over 4 requests -> 4 responses on 4 consecutive cycles, in order.
- Sticky overflow:
  - flags_in=3'b100 with flags_we=1 -> sticky_v=1; it stays 1 after a later flags_in=3'b000.
  - sticky_clr=1 together with a V=1 load -> sticky_v stays 1.
  - sticky_clr=1 alone -> sticky_v=0.

Source files
------------

// File: rtl/branch_cond_unit_if.sv
// Bus bundle between the branch condition unit and its producer/consumer.
// The unit side uses the slave modport; the driving side uses master.
interface branch_cond_unit_if #(
   parameter int W = 16
);
   logic          flags_we;
   logic [2:0]    flags_in;
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_cond;
   logic [W-1:0]  req_pc;
   logic [W-1:0]  req_target;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_taken;
   logic [W-1:0]  resp_next_pc;
   logic [2:0]    flags_q;
   logic          sticky_v;
   logic          sticky_clr;

   modport master (
      output flags_we, flags_in, req_valid, req_cond, req_pc, req_target,
             resp_ready, sticky_clr,
      input  req_ready, resp_valid, resp_taken, resp_next_pc, flags_q, sticky_v
   );

   modport slave (
      input  flags_we, flags_in, req_valid, req_cond, req_pc, req_target,
             resp_ready, sticky_clr,
      output req_ready, resp_valid, resp_taken, resp_next_pc, flags_q, sticky_v
   );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: holds ALU flags {V,N,Z}, resolves branch conditions and
// hands the next PC to fetch through a single-entry valid/ready output register.
module branch_cond_unit #(
   parameter int W      = 16,
   parameter int PC_INC = 1
) (
   input logic              clk,
   input logic              rst_n,
   branch_cond_unit_if.slave bus
);

   localparam logic [W-1:0] PcIncW = W'(PC_INC);

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    flagsReg_q;
   logic          sticky_q;
   logic          respTaken_q;
   logic [W-1:0]  respPc_q;

   logic          reqReady;
   logic          respValid;
   logic          accept;
   logic [2:0]    eff;
   logic          lessThan;
   logic          condTaken;
   logic [W-1:0]  nextPc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (bus.resp_ready && !bus.req_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // req_ready depends on resp_ready only, never on req_valid.
   always_comb begin
      reqReady  = 1'b0;
      respValid = 1'b0;
      case (state_q)
         IDLE: begin
            reqReady  = 1'b1;
            respValid = 1'b0;
         end
         FULL: begin
            reqReady  = bus.resp_ready;
            respValid = 1'b1;
         end
         default: begin
            reqReady  = 1'b0;
            respValid = 1'b0;
         end
      endcase
   end

   assign accept = bus.req_valid & reqReady;

   // A flag load in the acceptance cycle is bypassed straight into evaluation.
   always_comb begin
      eff       = bus.flags_we ? bus.flags_in : flagsReg_q;
      lessThan  = eff[1] ^ eff[2];
      condTaken = 1'b0;
      case (bus.req_cond)
         3'b000:  condTaken = 1'b1;
         3'b001:  condTaken = eff[0];
         3'b010:  condTaken = ~eff[0];
         3'b011:  condTaken = lessThan;
         3'b100:  condTaken = lessThan | eff[0];
         3'b101:  condTaken = ~lessThan;
         3'b110:  condTaken = ~lessThan & ~eff[0];
         3'b111:  condTaken = eff[2];
         default: condTaken = 1'b0;
      endcase
      nextPc = condTaken ? bus.req_target : bus.req_pc + PcIncW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         respTaken_q <= 1'b0;
         respPc_q    <= '0;
      end else if (accept) begin
         respTaken_q <= condTaken;
         respPc_q    <= nextPc;
      end
   end

   // Sticky overflow: a V=1 load wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flagsReg_q <= 3'b000;
         sticky_q   <= 1'b0;
      end else begin
         if (bus.flags_we) begin
            flagsReg_q <= bus.flags_in;
         end
         if (bus.flags_we && bus.flags_in[2]) begin
            sticky_q <= 1'b1;
         end else if (bus.sticky_clr) begin
            sticky_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready    = reqReady;
   assign bus.resp_valid   = respValid;
   assign bus.resp_taken   = respTaken_q;
   assign bus.resp_next_pc = respPc_q;
   assign bus.flags_q      = flagsReg_q;
   assign bus.sticky_v     = sticky_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_branch_cond_unit;

   logic clk;
   logic rst_n;

   int nChecks;
   int nFail;

   typedef struct {
      logic        taken;
      logic [15:0] nextPc;
   } resp_t;

   resp_t      mQ[$];
   logic [2:0] mFlags;
   logic       mSticky;

   branch_cond_unit_if #(.W(16)) bus ();

   branch_cond_unit #(.W(16), .PC_INC(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Condition rules stated as signed-compare relations on the flags.
   function automatic logic modelCond(input logic [2:0] c, input logic [2:0] f);
      logic v, n, z, less;
      v = f[2];
      n = f[1];
      z = f[0];
      less = (n != v);
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return z;
         3'd2:    return !z;
         3'd3:    return less;
         3'd4:    return less || z;
         3'd5:    return !less;
         3'd6:    return !less && !z;
         default: return v;
      endcase
   endfunction

   // Reference model: a queue holding at most one outstanding response.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mQ.delete();
         mFlags  = 3'b000;
         mSticky = 1'b0;
      end else begin
         logic       ready;
         logic [2:0] effFlags;
         resp_t      r;
         int         fall;
         ready = (mQ.size() == 0) || bus.resp_ready;
         if (mQ.size() != 0 && bus.resp_ready) begin
            void'(mQ.pop_front());
         end
         if (bus.req_valid && ready) begin
            effFlags = bus.flags_we ? bus.flags_in : mFlags;
            r.taken  = modelCond(bus.req_cond, effFlags);
            fall     = (int'(bus.req_pc) + 1) % 65536;
            r.nextPc = r.taken ? bus.req_target : 16'(fall);
            mQ.push_back(r);
         end
         if (bus.flags_we) begin
            mFlags = bus.flags_in;
         end
         if (bus.flags_we && bus.flags_in[2]) begin
            mSticky = 1'b1;
         end else if (bus.sticky_clr) begin
            mSticky = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      checkOutput("resp_valid", 32'(bus.resp_valid), 32'(mQ.size() != 0));
      checkOutput("req_ready", 32'(bus.req_ready), 32'((mQ.size() == 0) || bus.resp_ready));
      checkOutput("flags_q", 32'(bus.flags_q), 32'(mFlags));
      checkOutput("sticky_v", 32'(bus.sticky_v), 32'(mSticky));
      if (mQ.size() != 0) begin
         checkOutput("resp_taken", 32'(bus.resp_taken), 32'(mQ[0].taken));
         checkOutput("resp_next_pc", 32'(bus.resp_next_pc), 32'(mQ[0].nextPc));
      end
   end

   task automatic applyStimulus(input logic fwe, input logic [2:0] fin, input logic rv,
                                input logic [2:0] cond, input logic [15:0] pc,
                                input logic [15:0] tgt, input logic rr, input logic sclr);
      bus.flags_we   = fwe;
      bus.flags_in   = fin;
      bus.req_valid  = rv;
      bus.req_cond   = cond;
      bus.req_pc     = pc;
      bus.req_target = tgt;
      bus.resp_ready = rr;
      bus.sticky_clr = sclr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  expTaken;
      logic [15:0] tgts[4];
      logic        t;
      nChecks = 0;
      nFail   = 0;
      rst_n   = 1'b0;
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
      #12;
      checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("reset resp_next_pc", 32'(bus.resp_next_pc), 32'h0);
      checkOutput("reset resp_taken", 32'(bus.resp_taken), 32'h0);
      rst_n = 1'b1;
      step();

      applyStimulus(1'b1, 3'b100, 1'b1, 3'd0, 16'h0040, 16'h0800, 1'b0, 1'b0);
      step();
      checkOutput("full resp_valid", 32'(bus.resp_valid), 32'h1);
      checkOutput("full sticky_v", 32'(bus.sticky_v), 32'h1);
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset resp_valid", 32'(bus.resp_valid), 32'h0);
      checkOutput("async reset flags_q", 32'(bus.flags_q), 32'h0);
      checkOutput("async reset sticky_v", 32'(bus.sticky_v), 32'h0);
      #3 rst_n = 1'b1;
      step();

      applyStimulus(1'b1, 3'b010, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      checkOutput("flag load", 32'(bus.flags_q), 32'h2);

      expTaken = 8'b0001_1101;
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 3'b000, 1'b1, 3'(c), 16'h0010, 16'h0100, 1'b1, 1'b0);
         step();
         t = expTaken[c];
         checkOutput($sformatf("sweep taken c%0d", c), 32'(bus.resp_taken), 32'(t));
         checkOutput($sformatf("sweep pc c%0d", c), 32'(bus.resp_next_pc),
                     t ? 32'h0100 : 32'h0011);
      end
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      checkOutput("drain to idle", 32'(bus.resp_valid), 32'h0);

      applyStimulus(1'b1, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, 3'b001, 1'b1, 3'd1, 16'h0010, 16'h0200, 1'b1, 1'b0);
      step();
      checkOutput("bypass taken", 32'(bus.resp_taken), 32'h1);
      checkOutput("bypass pc", 32'(bus.resp_next_pc), 32'h0200);

      applyStimulus(1'b0, 3'b000, 1'b1, 3'd2, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
      step();
      checkOutput("wrap taken", 32'(bus.resp_taken), 32'h0);
      checkOutput("wrap pc", 32'(bus.resp_next_pc), 32'h0000);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'b000, 1'b1, 3'd0, 16'h0, 16'h0ABC, 1'b0, 1'b0);
         #3;
         checkOutput("hold req_ready", 32'(bus.req_ready), 32'h0);
         step();
         checkOutput("hold resp_valid", 32'(bus.resp_valid), 32'h1);
         checkOutput("hold resp_taken", 32'(bus.resp_taken), 32'h0);
         checkOutput("hold resp_next_pc", 32'(bus.resp_next_pc), 32'h0000);
      end

      tgts[0] = 16'h00A0;
      tgts[1] = 16'h00A1;
      tgts[2] = 16'h00A2;
      tgts[3] = 16'h00A3;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 3'b000, 1'b1, 3'd0, 16'h0, tgts[i], 1'b1, 1'b0);
         step();
         checkOutput($sformatf("stream pc %0d", i), 32'(bus.resp_next_pc), 32'(tgts[i]));
         checkOutput($sformatf("stream valid %0d", i), 32'(bus.resp_valid), 32'h1);
      end
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      checkOutput("stream end idle", 32'(bus.resp_valid), 32'h0);

      applyStimulus(1'b1, 3'b100, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      checkOutput("sticky set", 32'(bus.sticky_v), 32'h1);
      applyStimulus(1'b1, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      checkOutput("sticky holds", 32'(bus.sticky_v), 32'h1);
      applyStimulus(1'b1, 3'b100, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
      step();
      checkOutput("sticky set beats clr", 32'(bus.sticky_v), 32'h1);
      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1);
      step();
      checkOutput("sticky clr", 32'(bus.sticky_v), 32'h0);

      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                       $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)),
                       16'($urandom()), 16'($urandom()),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         step();
      end

      applyStimulus(1'b0, 3'b000, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
